message_packetizer: RTL and testbench
=====================================

// Module: message_packetizer
// PURPOSE
//   Upstream stage of the message stream combiner: turns a raw word stream
//   (in_data/in_nd) into message-stream packets, each a header word followed
//   by its payload words. Output drives one combiner input (in_data/in_nd).
//   Words are buffered in a circular RAM so the header can be emitted first.
// PARAMETERS
//   WIDTH                  32  word width; header bit is WIDTH-1
//   PACKET_LENGTH          16  payload words per auto-closed packet (1..MAX, <=BUFFER_LENGTH)
//   BUFFER_LENGTH          64  payload RAM depth (power of 2)
//   LOG_BUFFER_LENGTH       6  log2(BUFFER_LENGTH)
//   MAX_PACKET_LENGTH    1024  largest length encodable in header
//   LOG_MAX_PACKET_LENGTH  10  header length-field width
// PORTS
//   clk      in   1      clock; all state on posedge
//   rst      in   1      asynchronous reset, active-high
//   in_data  in   WIDTH  payload word
//   in_nd    in   1      in_data valid this cycle
//   flush    in   1      close the open packet early
//   out_data out  WIDTH  message-stream word
//   out_nd   out  1      out_data valid this cycle (no backpressure)
//   error    out  1      sticky: input word dropped
// BEHAVIOUR
//   - Reset (async, any time): out_nd=0, out_data=0, error=0, buffer,
//     length queue, open-packet count, FSM cleared; partial packet discarded.
//   - Header: bit WIDTH-1=1, bits [WIDTH-2 -: LOG_MAX_PACKET_LENGTH]=payload
//     count L (words following header), all other bits 0. L is never 0.
//   - Write: in_nd with occupancy<BUFFER_LENGTH stores word, count+=1.
//     Occupancy = open + committed-unsent words; a same-cycle write and
//     payload read both count (net 0). in_nd at occupancy==BUFFER_LENGTH:
//     word dropped, error<=1, count unchanged.
//   - Close: packet closes at the edge where count reaches PACKET_LENGTH, or
//     where flush=1 and count (including an accepted same-cycle write) >0.
//     Close pushes L into a length queue of depth BUFFER_LENGTH (cannot
//     overflow), count<=0. flush with count 0 and no accepted write: no-op.
//     flush coincident with auto-close: single packet.
//   - Output FSM, states IDLE/HEADER/PAYLOAD:
//     IDLE: length queue non-empty -> pop L, next cycle out_nd=1, out_data=
//       header (HEADER). Packet closed at edge k gives header at edge k+1.
//     HEADER -> PAYLOAD: emit L buffered words on L consecutive cycles, each
//       frees one RAM slot; payload words sent unmodified (MSB may be 1).
//     Last payload word: queue non-empty -> next cycle is the next header
//       (no gap); else IDLE with out_nd=0.
//   - out_data holds last value when out_nd=0.
//   - Full-rate input grows occupancy by 1 word per packet (L+1 outputs per
//     L inputs); sustained full rate eventually overflows -> error.
//   - RAM read is registered; FSM prefetches so payload is gapless.
//   - Pointers wrap modulo BUFFER_LENGTH.
// TESTING (WIDTH=32, LOG_MAX_PACKET_LENGTH=10)
//   1 PACKET_LENGTH=4; in_nd 4 cycles 0x11..0x14 -> 0x80800000, 0x11..0x14
//     on 5 consecutive out_nd cycles, header 1 cycle after 4th write.
//   2 PACKET_LENGTH=4; 12 consecutive words -> 3 packets, 15 consecutive
//     out_nd cycles, no gaps, error=0.
//   3 2 words 0xA,0xB then flush -> 0x80400000, 0xA, 0xB; flush again
//     with no data -> no output.
//   4 BUFFER_LENGTH=8, PACKET_LENGTH=4; 100 consecutive words -> error=1;
//     every header L equals its payload count; no packet corrupted.
//   5 rst asserted mid-payload -> out_nd=0, out_data=0 same cycle; after
//     release 4 words -> one clean packet, no stale words.
//   6 flush with in_nd when count=3 (PACKET_LENGTH=4) -> one packet L=4.

Source files
------------

// File: rtl/message_packetizer_if.sv
// Word-stream interface of the message packetizer: raw input words plus flush
// on one side, message-stream words and the sticky drop flag on the other.
interface message_packetizer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_nd;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_nd;
    logic             error;

    modport master (
        output in_data,
        output in_nd,
        output flush,
        input  out_data,
        input  out_nd,
        input  error
    );

    modport slave (
        input  in_data,
        input  in_nd,
        input  flush,
        output out_data,
        output out_nd,
        output error
    );
endinterface

// File: rtl/message_packetizer.sv
// Packs a raw word stream into header-first message-stream packets, buffering
// payload words in a circular RAM until their packet is closed.
module message_packetizer #(
    parameter int WIDTH                 = 32,
    parameter int PACKET_LENGTH         = 16,
    parameter int BUFFER_LENGTH         = 64,
    parameter int LOG_BUFFER_LENGTH     = 6,
    parameter int MAX_PACKET_LENGTH     = 1024,
    parameter int LOG_MAX_PACKET_LENGTH = 10
) (
    input logic                clk,
    input logic                rst,
    message_packetizer_if.slave bus
);
    localparam int CW   = LOG_BUFFER_LENGTH + 1;
    localparam int LW   = LOG_MAX_PACKET_LENGTH;
    localparam int PW   = LOG_BUFFER_LENGTH;

    localparam logic [CW-1:0] BUF_FULL = CW'(BUFFER_LENGTH);
    localparam logic [CW-1:0] PKT_LEN  = CW'(PACKET_LENGTH);
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] REM_ONE  = {{(LW-1){1'b0}}, 1'b1};

    if (PACKET_LENGTH < 1 || PACKET_LENGTH > MAX_PACKET_LENGTH ||
        PACKET_LENGTH > BUFFER_LENGTH) begin : g_param_check
        $error("message_packetizer: PACKET_LENGTH out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] make_header(input logic [LW-1:0] len);
        logic [WIDTH-1:0] hdr;
        hdr                = {WIDTH{1'b0}};
        hdr[WIDTH-1]       = 1'b1;
        hdr[WIDTH-2 -: LW] = len;
        return hdr;
    endfunction

    logic [WIDTH-1:0] mem [BUFFER_LENGTH];
    logic [LW-1:0]    len_q [BUFFER_LENGTH];

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    occ_r;
    logic [CW-1:0]    count_r;
    logic [PW-1:0]    q_head_r;
    logic [PW-1:0]    q_tail_r;
    logic [CW-1:0]    q_count_r;
    logic [WIDTH-1:0] rd_data_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_nd_r;
    logic             error_r;
    logic [LW-1:0]    rem_r;
    state_t           state_r;

    logic             wr_acc_s;
    logic [CW-1:0]    count_next_s;
    logic             close_s;
    logic             q_nonempty_s;
    logic             pop_s;
    logic             free_s;
    logic [LW-1:0]    len_head_s;

    assign wr_acc_s     = bus.in_nd && (occ_r < BUF_FULL);
    assign count_next_s = count_r + CW'(wr_acc_s);
    assign close_s      = (count_next_s == PKT_LEN) ||
                          (bus.flush && (count_next_s != {CW{1'b0}}));
    assign q_nonempty_s = (q_count_r != {CW{1'b0}});
    // A header may start from IDLE or straight after the last payload word.
    assign pop_s        = q_nonempty_s &&
                          ((state_r == IDLE) || (rem_r == {LW{1'b0}}));
    assign free_s       = (state_r != IDLE) && (rem_r != {LW{1'b0}});
    assign len_head_s   = len_q[q_head_r];

    assign bus.out_data = out_data_r;
    assign bus.out_nd   = out_nd_r;
    assign bus.error    = error_r;

    // Payload RAM and length queue storage; registered RAM read at rd_ptr_r.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_ptr_r] <= bus.in_data;
        end
        if (close_s) begin
            len_q[q_tail_r] <= LW'(count_next_s);
        end
        rd_data_r <= mem[rd_ptr_r];
    end

    // Write side: open-packet count, occupancy, length queue and drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {PW{1'b0}};
            occ_r     <= {CW{1'b0}};
            count_r   <= {CW{1'b0}};
            q_head_r  <= {PW{1'b0}};
            q_tail_r  <= {PW{1'b0}};
            q_count_r <= {CW{1'b0}};
            error_r   <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            count_r   <= close_s ? {CW{1'b0}} : count_next_s;
            occ_r     <= occ_r + CW'(wr_acc_s) - CW'(free_s);
            if (close_s) begin
                q_tail_r <= q_tail_r + PTR_ONE;
            end
            if (pop_s) begin
                q_head_r <= q_head_r + PTR_ONE;
            end
            q_count_r <= q_count_r + CW'(close_s) - CW'(pop_s);
            error_r   <= error_r | (bus.in_nd & ~wr_acc_s);
        end
    end

    // Output FSM; rd_ptr_r runs one word ahead so rd_data_r is ready each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rem_r      <= {LW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            out_data_r <= {WIDTH{1'b0}};
            out_nd_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        out_data_r <= make_header(len_head_s);
                        out_nd_r   <= 1'b1;
                        rem_r      <= len_head_s;
                        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                        state_r    <= HEADER;
                    end else begin
                        out_nd_r   <= 1'b0;
                    end
                end
                HEADER, PAYLOAD: begin
                    if (rem_r != {LW{1'b0}}) begin
                        out_data_r <= rd_data_r;
                        out_nd_r   <= 1'b1;
                        rem_r      <= rem_r - REM_ONE;
                        if (rem_r != REM_ONE) begin
                            rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        end else begin
                            rd_ptr_r <= rd_ptr_r;
                        end
                        state_r    <= PAYLOAD;
                    end else if (pop_s) begin
                        out_data_r <= make_header(len_head_s);
                        out_nd_r   <= 1'b1;
                        rem_r      <= len_head_s;
                        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                        state_r    <= HEADER;
                    end else begin
                        out_nd_r   <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    out_nd_r <= 1'b0;
                    rem_r    <= {LW{1'b0}};
                    state_r  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_message_packetizer.sv
// Randomized and directed bench for message_packetizer against a packet-level
// reference model that schedules each closed packet on the output timeline.
module tb_message_packetizer;
    localparam int WIDTH = 32;
    localparam int PL    = 4;
    localparam int BL    = 8;
    localparam int LBL   = 3;
    localparam int MPL   = 1024;
    localparam int LMPL  = 10;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    message_packetizer_if #(.WIDTH(WIDTH)) bus ();

    message_packetizer #(
        .WIDTH                 (WIDTH),
        .PACKET_LENGTH         (PL),
        .BUFFER_LENGTH         (BL),
        .LOG_BUFFER_LENGTH     (LBL),
        .MAX_PACKET_LENGTH     (MPL),
        .LOG_MAX_PACKET_LENGTH (LMPL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] hdr_word(input int len);
        return 32'h8000_0000 | (32'(len) << 21);
    endfunction

    // Reference model: expected output word per clock edge number.
    logic [31:0] exp_map [int];
    logic [31:0] m_open [$];
    int          m_emit [$];
    int          m_acc     = 0;
    int          m_freed   = 0;
    int          m_free_at = 0;
    logic        m_err     = 1'b0;
    int          e_mod;
    int          occ;
    int          start;
    logic        acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_map.delete();
            m_open.delete();
            m_emit.delete();
            m_acc     = 0;
            m_freed   = 0;
            m_free_at = 0;
            m_err     = 1'b0;
        end else begin
            e_mod = int'(($time + 5) / 10);
            while (m_emit.size() > 0 && m_emit[0] < e_mod) begin
                void'(m_emit.pop_front());
                m_freed++;
            end
            occ = m_acc - m_freed;
            acc = bus.in_nd && (occ < BL);
            if (bus.in_nd && !acc) m_err = 1'b1;
            if (acc) begin
                m_open.push_back(bus.in_data);
                m_acc++;
            end
            if (m_open.size() == PL || (bus.flush && m_open.size() > 0)) begin
                start = (e_mod + 1 > m_free_at) ? e_mod + 1 : m_free_at;
                exp_map[start] = hdr_word(m_open.size());
                foreach (m_open[i]) begin
                    exp_map[start + 1 + i] = m_open[i];
                    m_emit.push_back(start + 1 + i);
                end
                m_free_at = start + m_open.size() + 1;
                m_open.delete();
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model timeline.
    logic [31:0] m_last = 32'h0;
    logic        exp_nd;
    int          e_chk;

    always @(negedge clk) begin
        e_chk = int'($time / 10);
        if (rst) m_last = 32'h0;
        if (!rst && exp_map.exists(e_chk)) begin
            exp_nd = 1'b1;
            m_last = exp_map[e_chk];
        end else begin
            exp_nd = 1'b0;
        end
        check_eq("out_nd",   {31'b0, bus.out_nd}, {31'b0, exp_nd});
        check_eq("out_data", bus.out_data, m_last);
        check_eq("error",    {31'b0, bus.error}, {31'b0, m_err});
    end

    task automatic drive(input logic nd, input logic [31:0] d, input logic fl);
        @(negedge clk);
        bus.in_nd   = nd;
        bus.in_data = d;
        bus.flush   = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.in_nd   = 1'b0;
        bus.in_data = 32'h0;
        bus.flush   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_out_nd", {31'b0, bus.out_nd}, 32'h0);
        check_eq("rst_out_data", bus.out_data, 32'h0);

        // Auto-closed packet of four words; header one edge after last write.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h11 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_eq("t1_header", bus.out_data, 32'h8080_0000);
        check_eq("t1_hdr_nd", {31'b0, bus.out_nd}, 32'h1);
        idle(8);

        // Twelve back-to-back words: three gapless packets, no drop.
        for (int i = 0; i < 12; i++) drive(1'b1, 32'h100 + 32'(i), 1'b0);
        idle(20);
        check_eq("t2_no_error", {31'b0, bus.error}, 32'h0);

        // Flush after two words, then an empty flush.
        drive(1'b1, 32'hA, 1'b0);
        drive(1'b1, 32'hB, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_eq("t3_header", bus.out_data, 32'h8040_0000);
        idle(6);
        drive(1'b0, 32'h0, 1'b1);
        idle(6);

        // Flush together with the fourth word gives a single L=4 packet.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h60 + 32'(i), 1'b0);
        drive(1'b1, 32'h63, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        check_eq("t6_header", bus.out_data, 32'h8080_0000);
        idle(8);

        // Sustained full rate overflows the 8-word buffer.
        for (int i = 0; i < 100; i++) drive(1'b1, $urandom, 1'b0);
        idle(30);
        check_eq("t4_error", {31'b0, bus.error}, 32'h1);

        // Reset in the middle of a payload.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_rst_nd", {31'b0, bus.out_nd}, 32'h0);
        check_eq("t5_rst_data", bus.out_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0);
        idle(10);

        // Randomized traffic with varying input density and flushes.
        for (int blk = 0; blk < 15; blk++) begin
            int dens;
            dens = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 70 : 100);
            for (int i = 0; i < 100; i++) begin
                drive(($urandom_range(99) < dens) ? 1'b1 : 1'b0,
                      $urandom,
                      ($urandom_range(99) < 6) ? 1'b1 : 1'b0);
            end
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
